// File: rtl/spi_arbiter.sv
// Round-robin arbiter and sequencer sharing one SPI master between N_REQ requesters.
// Latches the winner's word, handshakes start/cs/done with the master and reports ack or timeout err.
module spi_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] din,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    err,
  output logic [N_REQ-1:0]    grant,
  output logic                busy,
  output logic                m_start,
  output logic [DW-1:0]       m_din,
  input  logic                m_cs,
  input  logic                m_done,
  output logic [N_REQ-1:0]    ss_n
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, XFER, RELEASE} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic              start_q, start_d;
  logic [DW-1:0]     din_q, din_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q;

  logic              win_valid;
  logic [PW-1:0]     win_idx, scan_idx, ptr_nxt;
  logic [N_REQ-1:0]  win_onehot;
  logic [DW-1:0]     win_word;
  logic              done_rise, cnt_last;

  assign done_rise = m_done & ~done_q;
  assign cnt_last  = (cnt_q == CW'(TIMEOUT - 1));

  // Rotating scan from ptr_q; the first asserted request met wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_valid && req[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
      scan_idx = (scan_idx == PW'(N_REQ - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  always_comb begin
    win_onehot = '0;
    win_word   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_onehot[i] = 1'b1;
        win_word      = din[i*DW +: DW];
      end
    end
  end

  assign ptr_nxt = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  // NOTE: every *_d gets its hold/idle value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    err_d   = '0;
    start_d = start_q;
    din_d   = din_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_onehot;
          din_d   = win_word;
          ptr_d   = ptr_nxt;
          cnt_d   = '0;
          start_d = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!m_cs) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = XFER;
        end else if (cnt_last) begin
          start_d = 1'b0;
          err_d   = grant_q;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER: begin
        if (done_rise) begin
          ack_d   = grant_q;
          state_d = RELEASE;
        end else if (cnt_last) begin
          err_d   = grant_q;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        // Hold grant until the master has left its end state, so ss_n follows any late cs.
        if (m_cs && !m_done) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      din_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      start_q <= start_d;
      din_q   <= din_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= m_done;
    end
  end

  assign ack     = ack_q;
  assign err     = err_q;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign m_start = start_q;
  assign m_din   = din_q;
  assign ss_n    = ~grant_q | {N_REQ{m_cs}};

endmodule
